// File: rtl/axis_framer.sv
// rtl/axis_framer.sv - length-framed stream buffer: upstream words through a FIFO, tagged with last on beat len
module axis_framer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [31:0]      m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] beat_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [32:0]      mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [LEN_W-1:0] len_q;
  logic             full, empty, push, pop, push_last, start_ok;

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_ready   = (state == RUN) && !full;
  assign push      = s_valid && s_ready;
  assign m_valid   = !empty;
  assign pop       = m_valid && m_ready;
  assign push_last = (beat_cnt == len_q - LEN_W'(1));
  assign start_ok  = (state == IDLE) && start && (len != '0);
  assign busy      = (state != IDLE);

  // Head is read from registered storage; masked to zero while empty.
  assign {m_data, m_last} = empty ? 33'd0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)          state_nxt = RUN;
      RUN:     if (push && push_last) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last)     state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == DRAIN) && pop && m_last;
      if (start_ok) begin
        len_q    <= len;
        beat_cnt <= '0;
      end
      if (push) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
        wr_ptr   <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_data, push_last};
  end

endmodule

// File: tb/tb_axis_framer.sv
// tb/tb_axis_framer.sv - randomized scoreboard bench for axis_framer
module tb_axis_framer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             s_valid = 1'b0;
  logic [31:0]      s_data = '0;
  logic             s_ready;
  logic             m_valid;
  logic [31:0]      m_data;
  logic             m_last;
  logic             m_ready = 1'b0;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] beat_cnt;

  int vectors = 0;
  int miscompares = 0;

  axis_framer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: scoreboard queue of expected {data,last}, occupancy from push/pop counts.
  task automatic run_frame(input int flen, input int sv_pct, input int mr_pct, input int stall,
                           input bit seq, input logic [31:0] base, input bit poke_start);
    logic [32:0] q[$];
    int sent = 0;
    int occ = 0;
    int cyc = 0;
    bit done_exp = 0;
    bit finished = 0;
    bit push, pop;
    start = 1'b1; len = flen[LEN_W-1:0]; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %0b want 0", busy); end
    tick();
    start = 1'b0;
    while (!finished && cyc < 400) begin
      s_valid = ($urandom_range(99) < sv_pct);
      s_data  = seq ? base + 32'(sent) : $urandom;
      m_ready = (cyc >= stall) && ($urandom_range(99) < mr_pct);
      start   = poke_start && (cyc == 1);
      len     = start ? 16'd9 : flen[LEN_W-1:0];
      @(negedge clk);
      if (done_exp) begin
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          miscompares++; $display("FAIL done_pulse got done=%0b busy=%0b want 1/0", done, busy);
        end
        vectors++;
        if (beat_cnt !== flen[LEN_W-1:0]) begin
          miscompares++; $display("FAIL beat_cnt got %0d want %0d", beat_cnt, flen);
        end
        finished = 1;
      end else begin
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          miscompares++; $display("FAIL run_flags got done=%0b busy=%0b want 0/1", done, busy);
        end
        vectors++;
        if (s_ready !== (sent < flen && occ < DEPTH)) begin
          miscompares++; $display("FAIL s_ready got %0b want %0b (sent=%0d occ=%0d)", s_ready, (sent < flen && occ < DEPTH), sent, occ);
        end
        vectors++;
        if (m_valid !== (occ > 0)) begin
          miscompares++; $display("FAIL m_valid got %0b want %0b", m_valid, (occ > 0));
        end
        if (occ > 0) begin
          vectors++;
          if ({m_data, m_last} !== q[0]) begin
            miscompares++; $display("FAIL head got %h/%0b want %h/%0b", m_data, m_last, q[0][32:1], q[0][0]);
          end
        end
        push = s_valid && s_ready;
        pop  = m_valid && m_ready && (occ > 0);
        if (pop) begin
          if (q[0][0]) done_exp = 1;
          void'(q.pop_front());
          occ--;
        end
        if (push) begin
          q.push_back({s_data, sent == flen - 1});
          sent++;
          occ++;
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    if (!finished) begin
      vectors++; miscompares++;
      $display("FAIL frame_timeout got sent=%0d want done within 400 cycles", sent);
      reset = 1'b1; tick(); tick(); reset = 1'b0;
    end else begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL done_width got %0b want 0", done); end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    vectors++;
    if ({s_ready, m_valid, m_last, busy, done} !== 5'b0 || m_data !== 32'd0 || beat_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_vals got rdy=%0b mv=%0b ml=%0b busy=%0b done=%0b data=%h cnt=%0d want all 0",
               s_ready, m_valid, m_last, busy, done, m_data, beat_cnt);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_frame(3, 100, 100, 0, 1'b1, 32'hA, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame(8, 100, 100, 12, 1'b1, 32'h100, 1'b0);
  endtask

  task automatic test_len_zero();
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin
        miscompares++; $display("FAIL len_zero got busy=%0b rdy=%0b done=%0b want 0/0/0", busy, s_ready, done);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    run_frame(4, 100, 100, 0, 1'b1, 32'h20, 1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; len = 16'd6;
    tick();
    start = 1'b0; s_valid = 1'b1; m_ready = 1'b0; s_data = $urandom;
    tick();
    s_data = $urandom;
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (beat_cnt !== 16'd2) begin miscompares++; $display("FAIL mid_count got %0d want 2", beat_cnt); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || beat_cnt !== '0 || done !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset got mv=%0b busy=%0b cnt=%0d done=%0b want 0", m_valid, busy, beat_cnt, done);
    end
    tick();
    run_frame(2, 100, 100, 0, 1'b1, 32'h300, 1'b0);
  endtask

  task automatic test_len_one();
    run_frame(1, 100, 100, 0, 1'b1, 32'h55, 1'b0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 1000; f++) run_frame(5, 60, 60, 0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_start_ignored();
    test_reset_mid();
    test_len_one();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
